fetch_prefetch_queue: RTL and testbench
=======================================

// Module: fetch_prefetch_queue
// PURPOSE
//  Parametrised successor to the single-word fetch stage: issues sequential instruction reads
//  to the memory model, tolerates variable read latency, and buffers returned words with their
//  PC in a DEPTH-entry FIFO ahead of decode/execute. Supports PC redirect (branch/jump) with
//  flush of buffered and in-flight fetches. Sits between program_counter/memory and decode.
// PARAMETERS
//  XLEN      32        address/instruction width
//  DEPTH     4         queue entries, power of 2, >= 2; also max outstanding reads
//  RESET_PC  32'h0     first fetch address after reset (bits [1:0] must be 0)
// PORTS
//  clock             in   1        rising-edge clock
//  reset             in   1        synchronous, active-high
//  redirect_valid    in   1        load new fetch PC this cycle, flush queue
//  redirect_pc       in   XLEN     target PC; bits [1:0] ignored (treated as 0)
//  mem_read_enable   out  1        read request strobe, one word per asserted cycle
//  mem_read_address  out  XLEN     request address (current fetch PC)
//  mem_read_valid    in   1        read data valid; responses return in request order
//  mem_read_value    in   XLEN     returned instruction word
//  instr_valid       out  1        queue head valid
//  instr_ready       in   1        decode consumes head when instr_valid & instr_ready
//  instr             out  XLEN     head instruction; 32'h00000013 (NOP) when !instr_valid
//  instr_pc          out  XLEN     PC of head instruction; 0 when !instr_valid
//  queue_count       out  $clog2(DEPTH+1)  entries held
//  protocol_error    out  1        sticky: response received with nothing outstanding
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, queue empty, outstanding=0, discard=0, mem_read_enable=0,
//   mem_read_address=RESET_PC, instr_valid=0, instr=NOP, instr_pc=0, queue_count=0,
//   protocol_error=0. Reset mid-operation drops all entries and ignores later responses
//   to pre-reset requests only via discard? No: reset clears discard; bench must not
//   return pre-reset responses after reset.
//  Issue (combinational from registers): mem_read_enable = !reset & !redirect_valid &
//   (queue_count + outstanding < DEPTH). On issue edge: fetch_pc += 4 (wraps mod 2^XLEN),
//   outstanding += 1. mem_read_address = fetch_pc always.
//  Response: on edge with mem_read_valid: if discard>0, discard -= 1 and word dropped;
//   else if outstanding>0, {word, pc} written at tail, outstanding -= 1, queue_count += 1;
//   else protocol_error set, word dropped. Response PC tracked by a response-PC register
//   incremented by 4 per accepted response, loaded with redirect target on redirect.
//  Latency: word returned at edge N is visible on instr/instr_valid after edge N (next cycle);
//   earliest issue-to-head with 1-cycle memory = 2 cycles.
//  Dequeue: on edge with instr_valid & instr_ready, head advances, queue_count -= 1.
//   Simultaneous response-accept and dequeue: count unchanged, both take effect. Credit rule
//   guarantees no overflow; a write when full cannot occur.
//  Redirect (priority over everything): on edge with redirect_valid: queue emptied,
//   fetch_pc = response-PC = {redirect_pc[XLEN-1:2],2'b00}, discard += outstanding (minus
//   a response discarded that same edge), outstanding = 0, dequeue and any same-edge response
//   are dropped. No issue in the redirect cycle; issue resumes next cycle from new PC.
//  instr_valid/instr/instr_pc are registered (head of FIFO), never glitch on instr_ready.
// TESTING
//  1 reset, memory silent 3 cycles -> 1 request to 0x0 then more up to DEPTH=4 outstanding,
//    instr_valid=0, instr=0x00000013, queue_count=0.
//  2 1-cycle memory, instr_ready=1 -> steady one instr/cycle, instr_pc 0x0,0x4,0x8,... in
//    order, first instr_valid 2 cycles after first issue.
//  3 instr_ready=0 -> exactly 4 requests, queue_count=4, mem_read_enable stays 0; raise
//    instr_ready one cycle -> exactly one new request next cycle.
//  4 3-cycle memory, redirect to 0x103 with 3 outstanding -> next 3 responses dropped,
//    first delivered instr_pc=0x100, queue_count=0 right after redirect.
//  5 redirect to 0xFFFFFFF8 -> instr_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap).
//  6 redirect coinciding with response and dequeue -> neither applied, queue empty;
//    unsolicited mem_read_valid at idle -> protocol_error=1 and stays 1 until reset.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// Prefetching fetch stage: sequential reads, in-order responses buffered
// with their PC in a DEPTH-entry queue ahead of decode; redirect flushes.
module fetch_prefetch_queue #(
  parameter int          XLEN     = 32,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  localparam int         AW       = $clog2(DEPTH),
  localparam int         CW       = $clog2(DEPTH+1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_read_enable,
  output logic [XLEN-1:0] mem_read_address,
  input  logic            mem_read_valid,
  input  logic [XLEN-1:0] mem_read_value,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [CW-1:0]   queue_count,
  output logic            protocol_error
);

  // discard can pile up across back-to-back redirects
  localparam int DW = CW + 4;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   disc_q, disc_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic            perr_q, perr_d;
  logic [XLEN-1:0] word_q [DEPTH];
  logic [XLEN-1:0] pcs_q  [DEPTH];

  logic [XLEN-1:0] tgt;
  logic [CW:0]     occ;
  logic            issue, rsp_drop, rsp_acc, rsp_err, deq;

  assign tgt      = redirect_pc & ~XLEN'(3);
  assign occ      = {1'b0, cnt_q} + {1'b0, out_q};
  assign issue    = !reset && !redirect_valid
                    && (occ < (CW+1)'(DEPTH));
  assign rsp_drop = mem_read_valid && (disc_q != '0);
  assign rsp_acc  = mem_read_valid && (disc_q == '0)
                    && (out_q != '0);
  assign rsp_err  = mem_read_valid && (disc_q == '0)
                    && (out_q == '0);
  assign deq      = (cnt_q != '0) && instr_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q;
    cnt_d      = cnt_q;
    disc_d     = disc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    perr_d     = perr_q | rsp_err;
    if (redirect_valid) begin
      fetch_pc_d = tgt;
      resp_pc_d  = tgt;
      out_d      = '0;
      cnt_d      = '0;
      head_d     = '0;
      tail_d     = '0;
      disc_d     = disc_q + DW'(out_q)
                   - DW'(rsp_drop) - DW'(rsp_acc);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (rsp_drop) disc_d = disc_q - DW'(1);
      if (rsp_acc) begin
        tail_d    = tail_q + AW'(1);
        resp_pc_d = resp_pc_q + XLEN'(4);
      end
      if (deq) head_d = head_q + AW'(1);
      out_d = out_q + CW'(issue) - CW'(rsp_acc);
      cnt_d = cnt_q + CW'(rsp_acc) - CW'(deq);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC[XLEN-1:0];
      resp_pc_q  <= RESET_PC[XLEN-1:0];
      out_q      <= '0;
      cnt_q      <= '0;
      disc_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      perr_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      disc_q     <= disc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      perr_q     <= perr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !redirect_valid && rsp_acc) begin
      word_q[tail_q] <= mem_read_value;
      pcs_q[tail_q]  <= resp_pc_q;
    end
  end

  assign mem_read_enable  = issue;
  assign mem_read_address = fetch_pc_q;
  assign instr_valid      = cnt_q != '0;
  assign instr            = instr_valid ? word_q[head_q]
                                        : XLEN'(32'h13);
  assign instr_pc         = instr_valid ? pcs_q[head_q] : '0;
  assign queue_count      = cnt_q;
  assign protocol_error   = perr_q;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Random-stimulus bench for fetch_prefetch_queue against a queue-based
// reference model with an in-order variable-latency memory.
module tb_fetch_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_read_enable;
  logic [31:0] mem_read_address;
  logic        mem_read_valid;
  logic [31:0] mem_read_value;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [2:0]  queue_count;
  logic        protocol_error;

  fetch_prefetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_read_enable(mem_read_enable),
    .mem_read_address(mem_read_address),
    .mem_read_valid(mem_read_valid), .mem_read_value(mem_read_value),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .queue_count(queue_count), .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;
  typedef struct { logic [31:0] a; logic [31:0] w; bit stale; int due; } req_t;

  ent_t        mq[$];
  req_t        fl[$];
  logic [31:0] m_pc;
  bit          m_perr;
  int          cyc, nt, nf, lmin, lmax, nreq;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nt++;
    if (got !== exp) begin
      nf++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int live();
    int n = 0;
    foreach (fl[i]) if (!fl[i].stale) n++;
    return n;
  endfunction

  // Called just after a negedge: drive, check, advance model, cross one edge.
  task automatic step(input bit rdr, input logic [31:0] tgt, input bit rdy,
                      input bit rsp_on, input bit unsol);
    bit   rv, en, deq, acc;
    ent_t e;
    req_t r;
    rv = rsp_on && fl.size() > 0 && fl[0].due <= cyc;
    if (unsol && fl.size() == 0) rv = 1;
    redirect_valid = rdr;
    redirect_pc    = tgt;
    instr_ready    = rdy;
    mem_read_valid = rv;
    mem_read_value = (rv && fl.size() > 0) ? fl[0].w : $urandom;
    #1;
    en = !reset && !rdr && (mq.size() + live() < DEPTH);
    chk("rd_en", mem_read_enable, en);
    chk("rd_addr", mem_read_address, m_pc);
    chk("ivalid", instr_valid, mq.size() > 0);
    chk("instr", instr, mq.size() > 0 ? mq[0].w : 32'h13);
    chk("ipc", instr_pc, mq.size() > 0 ? mq[0].pc : 32'h0);
    chk("count", queue_count, mq.size());
    chk("perr", protocol_error, m_perr);
    if (mem_read_enable) nreq++;
    if (reset) begin
      mq.delete(); fl.delete(); m_pc = 32'h0; m_perr = 0;
    end else begin
      deq = mq.size() > 0 && rdy;
      acc = 0;
      if (rv) begin
        if (fl.size() == 0) m_perr = 1;
        else begin
          r = fl.pop_front();
          if (!r.stale) begin acc = 1; e.pc = r.a; e.w = r.w; end
        end
      end
      if (rdr) begin
        mq.delete();
        foreach (fl[i]) fl[i].stale = 1;
        m_pc = {tgt[31:2], 2'b00};
      end else begin
        if (deq) void'(mq.pop_front());
        if (acc) mq.push_back(e);
        if (en) begin
          r.a = m_pc; r.w = $urandom; r.stale = 0;
          r.due = cyc + int'($urandom_range(lmax, lmin));
          fl.push_back(r);
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  initial begin
    int guard;
    nt = 0; nf = 0; cyc = 0; nreq = 0;
    lmin = 1; lmax = 1;
    m_pc = 32'h0; m_perr = 0;
    reset = 1; redirect_valid = 0; redirect_pc = 0;
    instr_ready = 0; mem_read_valid = 0; mem_read_value = 0;
    @(negedge clock);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    reset = 0;

    // silent memory: exactly DEPTH requests go out
    nreq = 0;
    repeat (6) step(0, 0, 0, 0, 0);
    chk("silent_reqs", nreq, DEPTH);

    // 1-cycle memory, decode always ready
    repeat (30) step(0, 0, 1, 1, 0);

    // decode stalled: queue fills, then one slot frees
    repeat (10) step(0, 0, 0, 1, 0);
    chk("full_cnt", queue_count, 4);
    nreq = 0;
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("one_req", nreq, 1);

    // 3-cycle memory, redirect with three outstanding
    lmin = 3; lmax = 3;
    guard = 0;
    while (live() != 3 && guard < 30) begin
      step(0, 0, 1, 1, 0); guard++;
    end
    chk("three_out", live(), 3);
    step(1, 32'h103, 1, 1, 0);
    chk("rdr_empty", queue_count, 0);
    repeat (20) step(0, 0, 1, 1, 0);

    // wrap past the top of the address space
    lmin = 1; lmax = 1;
    step(1, 32'hFFFF_FFF8, 1, 1, 0);
    repeat (12) step(0, 0, 1, 1, 0);

    // random traffic with redirects
    lmin = 1; lmax = 4;
    repeat (400) begin
      step(($urandom_range(99) < 8), $urandom, ($urandom_range(99) < 70),
           1, 0);
    end

    // drain to idle, then an unsolicited response
    guard = 0;
    while (fl.size() != 0 && guard < 40) begin
      step(0, 0, 0, 1, 0); guard++;
    end
    chk("idle", fl.size(), 0);
    step(0, 0, 0, 1, 1);
    repeat (5) step(0, 0, 1, 1, 0);
    chk("perr_sticky", protocol_error, 1);

    reset = 1;
    step(0, 0, 0, 0, 0);
    reset = 0;
    step(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule
